// File: rtl/ps2_host_tx_if.sv
// Command/status bundle between the mouse init sequencer and the PS/2 host transmitter.
// The sequencer is the master; the transmitter is the slave.
interface ps2_host_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;
  logic       ack_ok;

  modport master (
    output wr_ps2, din,
    input  tx_idle, tx_done_tick, tx_err_tick, ack_ok
  );

  modport slave (
    input  wr_ps2, din,
    output tx_idle, tx_done_tick, tx_err_tick, ack_ok
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the device,
// ACK capture and overall transfer timeout. Lines are only ever pulled low or released.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  bus,
  inout  wire           ps2c,
  inout  wire           ps2d
);

  localparam int CNT_W  = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, ACK, FIN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [3:0]          n_q, n_d;
  logic [8:0]          sr_q, sr_d;
  logic                c_drv_q, c_drv_d;
  logic                d_drv_q, d_drv_d;
  logic                ack_ok_q, ack_ok_d;
  logic                done_w, err_w;

  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_sh_q;
  logic                  c_filt_q, c_filt_d;
  logic                  fall;

  // Synchronizers and glitch filter reset to the idle (released, high) line level
  // so that leaving reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      c_sync_q  <= 2'b11;
      d_sync_q  <= 2'b11;
      filt_sh_q <= '1;
      c_filt_q  <= 1'b1;
    end else begin
      c_sync_q  <= {c_sync_q[0], ps2c};
      d_sync_q  <= {d_sync_q[0], ps2d};
      filt_sh_q <= {filt_sh_q[FILTER_LEN-2:0], c_sync_q[1]};
      c_filt_q  <= c_filt_d;
    end
  end

  always_comb begin
    c_filt_d = c_filt_q;
    if (&filt_sh_q)       c_filt_d = 1'b1;
    else if (~|filt_sh_q) c_filt_d = 1'b0;
  end

  assign fall = c_filt_q & ~|filt_sh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      n_q      <= '0;
      sr_q     <= '0;
      c_drv_q  <= 1'b0;
      d_drv_q  <= 1'b0;
      ack_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      n_q      <= n_d;
      sr_q     <= sr_d;
      c_drv_q  <= c_drv_d;
      d_drv_q  <= d_drv_d;
      ack_ok_q <= ack_ok_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    n_d      = n_q;
    sr_d     = sr_q;
    c_drv_d  = c_drv_q;
    d_drv_d  = d_drv_q;
    ack_ok_d = ack_ok_q;
    done_w   = 1'b0;
    err_w    = 1'b0;

    if (state_q inside {START, DATA, ACK, FIN}) tcnt_d = tcnt_q + TCNT_W'(1);

    // Timeout wins over any falling edge seen in the same cycle.
    if ((state_q inside {START, DATA, ACK, FIN}) &&
        tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
      c_drv_d  = 1'b0;
      d_drv_d  = 1'b0;
      ack_ok_d = 1'b0;
      err_w    = 1'b1;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.wr_ps2) begin
          sr_d    = {~^bus.din, bus.din};
          cnt_d   = '0;
          c_drv_d = 1'b1;
          state_d = RTS;
        end
        RTS: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
            d_drv_d = 1'b1;
            c_drv_d = 1'b0;
            tcnt_d  = '0;
            state_d = START;
          end
        end
        START: if (fall) begin
          d_drv_d = ~sr_q[0];
          sr_d    = {1'b0, sr_q[8:1]};
          n_d     = '0;
          state_d = DATA;
        end
        DATA: if (fall) begin
          if (n_q == 4'd8) begin
            d_drv_d = 1'b0;
            state_d = ACK;
          end else begin
            d_drv_d = ~sr_q[0];
            sr_d    = {1'b0, sr_q[8:1]};
            n_d     = n_q + 4'd1;
          end
        end
        ACK: if (fall) begin
          ack_ok_d = ~d_sync_q[1];
          state_d  = FIN;
        end
        FIN: if (c_filt_q && d_sync_q[1]) begin
          done_w  = 1'b1;
          err_w   = ~ack_ok_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Ticks are decoded from the current state, so a strobe in the tick cycle still sees a busy transmitter.
  assign bus.tx_done_tick = done_w & ~reset;
  assign bus.tx_err_tick  = err_w & ~reset;
  assign bus.tx_idle      = (state_q == IDLE);
  assign bus.ack_ok       = ack_ok_q;

  assign ps2c = c_drv_q ? 1'b0 : 1'bz;
  assign ps2d = d_drv_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a pulled-up PS/2 device model clocks frames, samples data on
// rising edges and optionally ACKs; expected frames come from the byte value alone.
module tb_ps2_host_tx;

  logic clk = 1'b0;
  logic reset;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  wire  ps2c_w;
  wire  ps2d_w;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int err_cyc = 0;
  int wr_cyc = 0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(3000),
    .FILTER_LEN    (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .ps2c (ps2c_w),
    .ps2d (ps2d_w)
  );

  pullup (ps2c_w);
  pullup (ps2d_w);
  assign ps2c_w = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d_w = dev_d_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_done_tick) done_cnt <= done_cnt + 1;
    if (bus.tx_err_tick) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (bus.tx_done_tick && bus.tx_err_tick) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wire order: start 0, d0..d7, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_wr(input logic [7:0] b);
    @(negedge clk);
    bus.wr_ps2 = 1'b1;
    bus.din    = b;
    wr_cyc     = cyc;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
  endtask

  // Device side: measure the host's inhibit, then run 11 clocks of 20 low / 20 high cycles.
  task automatic device(input bit ack, input int abort_at, input bit inject,
                        output logic [10:0] got, output int low_cycles, output bit ok);
    int w;
    got = '0;
    low_cycles = 0;
    ok = 1'b1;
    w = 0;
    while (ps2c_w !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (ps2c_w !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    while (ps2c_w === 1'b0 && low_cycles < 200) begin
      low_cycles++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    got[0] = ps2d_w;
    for (int k = 1; k <= 11; k++) begin
      dev_c_low = 1'b1;
      for (int t = 0; t < 20; t++) begin
        if (inject && k == 5 && t == 10) begin
          bus.wr_ps2 = 1'b1;
          bus.din    = 8'hAA;
        end
        if (inject && k == 5 && t == 11) bus.wr_ps2 = 1'b0;
        @(negedge clk);
      end
      dev_c_low = 1'b0;
      if (k <= 10) got[k] = ps2d_w;
      if (k == abort_at) begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        return;
      end
      for (int t = 0; t < 20; t++) begin
        if (k == 10 && t == 5 && ack) dev_d_low = 1'b1;
        if (k == 11 && t == 2) dev_d_low = 1'b0;
        @(negedge clk);
      end
    end
    dev_d_low = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, input bit inject, input string tag);
    int d0, e0, b0, w, low;
    logic [10:0] got;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = both_cnt;
    start_wr(b);
    device(ack, 0, inject, got, low, ok);
    check({tag, "_rts_seen"}, 32'(ok), 32'd1);
    check({tag, "_inhibit_len"}, 32'(low), 32'd20);
    check({tag, "_frame"}, 32'(got), 32'(frame_of(b)));
    w = 0;
    while (bus.tx_idle !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_idle"}, 32'(bus.tx_idle), 32'd1);
    repeat (2) @(negedge clk);
    check({tag, "_done_ticks"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_err_ticks"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    check({tag, "_done_err_same"}, 32'(both_cnt - b0), ack ? 32'd0 : 32'd1);
    check({tag, "_ack_ok"}, 32'(bus.ack_ok), 32'(ack));
  endtask

  initial begin
    int d0, e0, w, lat, low;
    logic [10:0] got;
    bit ok;
    logic [7:0] rb;
    bit ra;

    reset      = 1'b1;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_idle", 32'(bus.tx_idle), 32'd1);
    check("rst_ack_ok", 32'(bus.ack_ok), 32'd0);
    check("rst_done", 32'(bus.tx_done_tick), 32'd0);
    check("rst_err", 32'(bus.tx_err_tick), 32'd0);
    check("rst_lines", {30'd0, ps2c_w, ps2d_w}, 32'd3);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    xfer(8'hF4, 1'b1, 1'b0, "f4_ack");
    xfer(8'hFF, 1'b1, 1'b0, "ff_ack");
    xfer(8'h00, 1'b0, 1'b0, "00_nack");

    // Device never clocks: transfer must give up after inhibit + timeout.
    d0 = done_cnt;
    e0 = err_cnt;
    start_wr(8'hF4);
    w = 0;
    while (err_cnt == e0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    check("to_err_ticks", 32'(err_cnt - e0), 32'd1);
    lat = err_cyc - wr_cyc;
    check("to_latency_in_window", 32'(lat >= 3018 && lat <= 3022), 32'd1);
    repeat (3) @(negedge clk);
    check("to_done_ticks", 32'(done_cnt - d0), 32'd0);
    check("to_lines_released", {30'd0, ps2c_w, ps2d_w}, 32'd3);
    check("to_idle", 32'(bus.tx_idle), 32'd1);
    check("to_ack_ok", 32'(bus.ack_ok), 32'd0);

    // Reset mid-frame after the 4th device clock.
    d0 = done_cnt;
    e0 = err_cnt;
    start_wr(8'hF4);
    device(1'b1, 4, 1'b0, got, low, ok);
    check("rstmid_rts_seen", 32'(ok), 32'd1);
    @(negedge clk);
    check("rstmid_lines_released", {30'd0, ps2c_w, ps2d_w}, 32'd3);
    check("rstmid_idle", 32'(bus.tx_idle), 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rstmid_no_err", 32'(err_cnt - e0), 32'd0);
    xfer(8'hF4, 1'b1, 1'b0, "f4_after_rst");

    // Strobe with 0xAA while busy must not disturb the frame.
    xfer(8'hF4, 1'b1, 1'b1, "f4_busy_wr");
    repeat (30) @(negedge clk);
    check("busy_wr_ignored_idle", 32'(bus.tx_idle), 32'd1);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      xfer(rb, ra, 1'b0, $sformatf("rand%0d_%02h_%0d", i, rb, ra));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
